// File: rtl/fpdiv_pkg.sv
// Shared types and widths for the iterative significand divider.
package fpdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MANT_W = 24;
  // Partial remainder stays below 2*divisor < 2^25, so two guard bits cover it.
  localparam int REM_W  = MANT_W + 2;
  localparam int QW_DEF = 26;

endpackage

// File: rtl/fpdiv_rstep.sv
// One radix-2 restoring step: trial subtract, quotient bit, and pre-shift for the next step.
module fpdiv_rstep
  import fpdiv_pkg::*;
(
  input  logic [REM_W-1:0]  rem,
  input  logic [MANT_W-1:0] divr,
  input  logic              last,
  output logic [REM_W-1:0]  rem_nxt,
  output logic              qbit
);

  logic [REM_W-1:0] divr_ext;
  logic [REM_W-1:0] diff;

  assign divr_ext = {2'b00, divr};
  assign qbit     = (rem >= divr_ext);
  assign diff     = qbit ? (rem - divr_ext) : rem;
  // The final remainder is kept unshifted so sticky reflects the true residue.
  assign rem_nxt  = last ? diff : {diff[REM_W-2:0], 1'b0};

endmodule

// File: rtl/fpdiv_mant_seq.sv
// Sequential restoring significand divider behind the start/done handshake of fpdiv.
module fpdiv_mant_seq
  import fpdiv_pkg::*;
#(
  parameter int R  = 2,
  parameter int QW = QW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic [QW-1:0]     quot,
  output logic              sticky,
  output logic              dz,
  output logic              busy,
  output logic              done
);

  localparam int NCYC = QW / R;
  localparam int CW   = $clog2(NCYC + 1);
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  state_t            state_q, state_d;
  logic              start_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [MANT_W-1:0] divr_q, divr_d;
  logic [QW-1:0]     quot_q, quot_d;
  logic              sticky_q, sticky_d;
  logic              dz_q, dz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              launch;
  logic              cnt_last;
  logic [R:0][REM_W-1:0] rem_ch;
  logic [R:0][QW-1:0]    quot_ch;

  assign launch   = start & ~start_q;
  assign cnt_last = (cnt_q == LAST);

  assign rem_ch[0]  = rem_q;
  assign quot_ch[0] = quot_q;

  // R restoring steps chained combinationally per clock.
  for (genvar i = 0; i < R; i++) begin : g_step
    localparam bit IS_TAIL = (i == R - 1);
    logic qbit;
    fpdiv_rstep u_step (
      .rem     (rem_ch[i]),
      .divr    (divr_q),
      .last    (IS_TAIL & cnt_last),
      .rem_nxt (rem_ch[i+1]),
      .qbit    (qbit)
    );
    assign quot_ch[i+1] = {quot_ch[i][QW-2:0], qbit};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    divr_d   = divr_q;
    quot_d   = quot_q;
    sticky_d = sticky_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (launch) begin
          done_d = 1'b0;
          if (mant_b[MANT_W-1]) begin
            rem_d   = {2'b00, mant_a};
            divr_d  = mant_b;
            cnt_d   = '0;
            quot_d  = '0;
            busy_d  = 1'b1;
            state_d = BUSY;
          end else begin
            // Unnormalized divisor: saturate now, raise done one cycle later.
            quot_d   = '1;
            sticky_d = 1'b0;
            dz_d     = 1'b1;
            busy_d   = 1'b0;
            state_d  = DONE;
          end
        end else if (state_q == DONE) begin
          done_d = 1'b1;
        end
      end
      BUSY: begin
        rem_d  = rem_ch[R];
        quot_d = quot_ch[R];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_last) begin
          sticky_d = |rem_ch[R];
          dz_d     = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      cnt_q    <= '0;
      quot_q   <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      sticky_q <= sticky_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Datapath registers carry no reset; they are reloaded on every launch.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    divr_q <= divr_d;
  end

  assign quot   = quot_q;
  assign sticky = sticky_q;
  assign dz     = dz_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fpdiv_mant_seq.sv
// Directed bench for fpdiv_mant_seq with R=2: results, latency, handshake and abort behaviour.
module tb_fpdiv_mant_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic [25:0] quot;
  logic        sticky;
  logic        dz;
  logic        busy;
  logic        done;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fpdiv_mant_seq #(.R(2), .QW(26)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mant_a (mant_a),
    .mant_b (mant_b),
    .quot   (quot),
    .sticky (sticky),
    .dz     (dz),
    .busy   (busy),
    .done   (done)
  );

  // Raise start so the next edge is the launching edge; returns 1ns after it.
  task automatic launch(input logic [23:0] a, input logic [23:0] b);
    mant_a = a;
    mant_b = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    mant_a = 24'h0;
    mant_b = 24'h0;
  endtask

  // Counts edges after the launching edge until done is seen, bounded at 40.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 40);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mant_a = '0; mant_b = '0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (quot !== 26'h0)   begin nfail++; $display("FAIL reset_quot got %h want 0", quot); end
    nvec++; if (sticky !== 1'b0)  begin nfail++; $display("FAIL reset_sticky got %b want 0", sticky); end
    nvec++; if (dz !== 1'b0)      begin nfail++; $display("FAIL reset_dz got %b want 0", dz); end
    nvec++; if (busy !== 1'b0)    begin nfail++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0)    begin nfail++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unity();
    int cyc;
    launch(24'h800000, 24'h800000);
    nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL unity_busy_e0 got %b want 1", busy); end
    nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL unity_done_e0 got %b want 0", done); end
    wait_done(cyc);
    nvec++; if (cyc != 13)          begin nfail++; $display("FAIL unity_latency got %0d want 13", cyc); end
    nvec++; if (quot !== 26'h2000000) begin nfail++; $display("FAIL unity_quot got %h want 2000000", quot); end
    nvec++; if (sticky !== 1'b0)    begin nfail++; $display("FAIL unity_sticky got %b want 0", sticky); end
    nvec++; if (dz !== 1'b0)        begin nfail++; $display("FAIL unity_dz got %b want 0", dz); end
    nvec++; if (busy !== 1'b0)      begin nfail++; $display("FAIL unity_busy_done got %b want 0", busy); end
  endtask

  task automatic test_values();
    int cyc;
    launch(24'hC00000, 24'h800000);
    wait_done(cyc);
    nvec++; if (cyc != 13)            begin nfail++; $display("FAIL three_half_latency got %0d want 13", cyc); end
    nvec++; if (quot !== 26'h3000000) begin nfail++; $display("FAIL three_half_quot got %h want 3000000", quot); end
    nvec++; if (sticky !== 1'b0)      begin nfail++; $display("FAIL three_half_sticky got %b want 0", sticky); end
    launch(24'h800000, 24'hC00000);
    wait_done(cyc);
    nvec++; if (quot !== 26'h1555555) begin nfail++; $display("FAIL two_thirds_quot got %h want 1555555", quot); end
    nvec++; if (sticky !== 1'b1)      begin nfail++; $display("FAIL two_thirds_sticky got %b want 1", sticky); end
    launch(24'hFFFFFF, 24'h800000);
    wait_done(cyc);
    nvec++; if (quot !== 26'h3FFFFFC) begin nfail++; $display("FAIL max_a_quot got %h want 3fffffc", quot); end
    nvec++; if (sticky !== 1'b0)      begin nfail++; $display("FAIL max_a_sticky got %b want 0", sticky); end
    launch(24'h800000, 24'hFFFFFF);
    wait_done(cyc);
    nvec++; if (quot !== 26'h1000001) begin nfail++; $display("FAIL max_b_quot got %h want 1000001", quot); end
    nvec++; if (sticky !== 1'b1)      begin nfail++; $display("FAIL max_b_sticky got %b want 1", sticky); end
  endtask

  task automatic test_div_zero();
    mant_a = 24'h9ABCDE;
    mant_b = 24'h400000;
    start  = 1'b1;
    @(posedge clk); #1;
    nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL dz_done_e0 got %b want 0", done); end
    @(posedge clk); #1;
    nvec++; if (done !== 1'b1)        begin nfail++; $display("FAIL dz_done_e1 got %b want 1", done); end
    nvec++; if (dz !== 1'b1)          begin nfail++; $display("FAIL dz_flag got %b want 1", dz); end
    nvec++; if (quot !== 26'h3FFFFFF) begin nfail++; $display("FAIL dz_quot got %h want 3ffffff", quot); end
    nvec++; if (sticky !== 1'b0)      begin nfail++; $display("FAIL dz_sticky got %b want 0", sticky); end
    start  = 1'b0;
    mant_b = 24'h800000;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (done !== 1'b1 || busy !== 1'b0) begin nfail++; $display("FAIL dz_held_start done=%b busy=%b want done=1 busy=0", done, busy); end
    nvec++; if (dz !== 1'b1) begin nfail++; $display("FAIL dz_held_start_dz got %b want 1", dz); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    // Launch straight from DONE while a pulse is injected mid-iteration.
    launch(24'hC00000, 24'h800000);
    nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL relaunch_done_drop got %b want 0", done); end
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) begin
        start  = 1'b1;
        mant_a = 24'h800000;
        mant_b = 24'hC00000;
      end
      if (cyc == 6) start = 1'b0;
    end while (!done && cyc < 40);
    nvec++; if (cyc != 13)            begin nfail++; $display("FAIL busy_pulse_latency got %0d want 13", cyc); end
    nvec++; if (quot !== 26'h3000000) begin nfail++; $display("FAIL busy_pulse_quot got %h want 3000000", quot); end
    nvec++; if (dz !== 1'b0)          begin nfail++; $display("FAIL busy_pulse_dz got %b want 0", dz); end
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (done !== 1'b1 || quot !== 26'h3000000) begin nfail++; $display("FAIL done_hold done=%b quot=%h want done=1 quot=3000000", done, quot); end
  endtask

  task automatic test_abort();
    int cyc;
    launch(24'h800000, 24'hC00000);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    nvec++; if (busy !== 1'b0)   begin nfail++; $display("FAIL abort_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0)   begin nfail++; $display("FAIL abort_done got %b want 0", done); end
    nvec++; if (quot !== 26'h0)  begin nfail++; $display("FAIL abort_quot got %h want 0", quot); end
    reset = 1'b1;
    cyc = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) cyc++;
    end
    nvec++; if (cyc != 0) begin nfail++; $display("FAIL abort_idle active_cycles got %0d want 0", cyc); end
    launch(24'hC00000, 24'h800000);
    wait_done(cyc);
    nvec++; if (cyc != 13 || quot !== 26'h3000000) begin nfail++; $display("FAIL abort_recover cyc=%0d quot=%h want 13 3000000", cyc, quot); end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_values();
    test_div_zero();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
